// File: rtl/harv_dmem_wb_bridge.sv
// rtl/harv_dmem_wb_bridge.sv - harv core dmem request/grant port to single-outstanding Wishbone data bus
module harv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req_i,
  input  logic        dmem_wren_i,
  input  logic [1:0]  dmem_ben_i,
  input  logic        dmem_usgn_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_gnt_o,
  output logic        dmem_err_o,
  output logic [31:0] dmem_rdata_o,
  output logic        data_mem_cyc_o,
  output logic        data_mem_stb_o,
  output logic        data_mem_we_o,
  output logic [3:0]  data_mem_wstrb_o,
  output logic [31:0] data_mem_addr_o,
  output logic [31:0] data_mem_data_o,
  input  logic [31:0] data_mem_data_i,
  input  logic        data_mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_usgn;
  logic        r_gnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_word;
  logic        w_half;
  logic        w_misal;
  logic [3:0]  w_strb;
  logic [31:0] w_wlanes;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic        w_expire;

  assign w_word  = dmem_ben_i[1];
  assign w_half  = (dmem_ben_i == 2'b01);
  assign w_misal = (w_word && (dmem_addr_i[1:0] != 2'b00)) || (w_half && dmem_addr_i[0]);

  always_comb begin
    w_strb   = 4'b0001 << dmem_addr_i[1:0];
    w_wlanes = {4{dmem_wdata_i[7:0]}};
    if (w_word) begin
      w_strb   = 4'b1111;
      w_wlanes = dmem_wdata_i;
    end else if (w_half) begin
      w_strb   = 4'b0011 << dmem_addr_i[1:0];
      w_wlanes = {2{dmem_wdata_i[15:0]}};
    end
  end

  // Load lane extraction uses the offset/size captured at request time.
  assign w_shift = data_mem_data_i >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    if (!r_size[1]) begin
      if (r_size[0])
        w_load = {{16{w_shift[15] & ~r_usgn}}, w_shift[15:0]};
      else
        w_load = {{24{w_shift[7] & ~r_usgn}}, w_shift[7:0]};
    end
  end

  // Count starts at 0 on the first BUS cycle, so expiry is the last allowed cycle.
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == (32'(TIMEOUT_CYCLES) - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_usgn  <= 1'b0;
      r_gnt   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_gnt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dmem_req_i) begin
            if (w_misal) begin
              r_gnt   <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= S_DONE;
            end else begin
              r_cyc   <= 1'b1;
              r_we    <= dmem_wren_i;
              r_wstrb <= w_strb;
              r_addr  <= {dmem_addr_i[31:2], 2'b00};
              r_wdata <= w_wlanes;
              r_off   <= dmem_addr_i[1:0];
              r_size  <= dmem_ben_i;
              r_usgn  <= dmem_usgn_i;
              r_cnt   <= '0;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (data_mem_ack_i) begin
            r_cyc   <= 1'b0;
            r_gnt   <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'd0 : w_load;
            r_state <= S_DONE;
          end else if (w_expire) begin
            r_cyc   <= 1'b0;
            r_gnt   <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_gnt_o       = r_gnt;
  assign dmem_err_o       = r_err;
  assign dmem_rdata_o     = r_rdata;
  assign data_mem_cyc_o   = r_cyc;
  assign data_mem_stb_o   = r_cyc;
  assign data_mem_we_o    = r_we;
  assign data_mem_wstrb_o = r_wstrb;
  assign data_mem_addr_o  = r_addr;
  assign data_mem_data_o  = r_wdata;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// tb/tb_harv_dmem_wb_bridge.sv - directed plus randomized checks of the dmem-to-Wishbone bridge
module tb_harv_dmem_wb_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req_i, dmem_wren_i, dmem_usgn_i;
  logic [1:0]  dmem_ben_i;
  logic [31:0] dmem_addr_i, dmem_wdata_i;
  logic        dmem_gnt_o, dmem_err_o;
  logic [31:0] dmem_rdata_o;
  logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
  logic [3:0]  data_mem_wstrb_o;
  logic [31:0] data_mem_addr_o, data_mem_data_o, data_mem_data_i;
  logic        data_mem_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  harv_dmem_wb_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .dmem_req_i(dmem_req_i), .dmem_wren_i(dmem_wren_i), .dmem_ben_i(dmem_ben_i),
    .dmem_usgn_i(dmem_usgn_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_gnt_o(dmem_gnt_o), .dmem_err_o(dmem_err_o), .dmem_rdata_o(dmem_rdata_o),
    .data_mem_cyc_o(data_mem_cyc_o), .data_mem_stb_o(data_mem_stb_o), .data_mem_we_o(data_mem_we_o),
    .data_mem_wstrb_o(data_mem_wstrb_o), .data_mem_addr_o(data_mem_addr_o),
    .data_mem_data_o(data_mem_data_o), .data_mem_data_i(data_mem_data_i),
    .data_mem_ack_i(data_mem_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from the core; k is the bus cycle carrying ack (0 = never).
  task automatic run(input logic wr, input logic [1:0] ben, input logic us,
                     input logic [31:0] a, input logic [31:0] wd, input int k,
                     input logic [31:0] bd);
    int n, off, exp_g, exp_ncyc, g, ncyc;
    logic exp_err, misal, gerr, cyc1, bad;
    logic [31:0] exp_rd, v, mask, exp_data, grd;
    logic [3:0] exp_strb;
    n        = ben[1] ? 4 : (ben[0] ? 2 : 1);
    off      = int'(a[1:0]);
    misal    = (off % n) != 0;
    exp_strb = 4'(((1 << n) - 1) << off);
    v        = bd >> (8 * off);
    exp_data = wd;
    if (n < 4) begin
      mask     = (32'd1 << (8 * n)) - 32'd1;
      exp_data = (wd & mask) * ((n == 1) ? 32'h01010101 : 32'h00010001);
      v        = v & mask;
      if (!us && v[8*n-1]) v = v | ~mask;
    end
    if (misal) begin
      exp_g = 1; exp_err = 1'b1; exp_rd = 0; exp_ncyc = 0;
    end else if (k >= 1 && k <= T) begin
      exp_g = k + 1; exp_err = 1'b0; exp_rd = wr ? 32'd0 : v; exp_ncyc = k;
    end else begin
      exp_g = T + 1; exp_err = 1'b1; exp_rd = 0; exp_ncyc = T;
    end

    dmem_wren_i = wr; dmem_ben_i = ben; dmem_usgn_i = us;
    dmem_addr_i = a;  dmem_wdata_i = wd; dmem_req_i = 1'b1;
    g = -1; ncyc = 0; gerr = 1'bx; grd = 'x; cyc1 = 1'b0; bad = 1'b0;
    for (int c = 1; c <= T + 4; c++) begin
      tick();
      if (data_mem_stb_o !== data_mem_cyc_o) bad = 1'b1;
      if (data_mem_cyc_o === 1'b1) begin
        ncyc++;
        if (c == 1) cyc1 = 1'b1;
        if (data_mem_we_o !== wr || data_mem_wstrb_o !== exp_strb ||
            data_mem_addr_o !== {a[31:2], 2'b00}) bad = 1'b1;
        if (wr && data_mem_data_o !== exp_data) bad = 1'b1;
      end
      if (dmem_gnt_o === 1'b1) begin
        g = c; gerr = dmem_err_o; grd = dmem_rdata_o;
        break;
      end
      data_mem_ack_i  = (c == k);
      data_mem_data_i = (c == k) ? bd : $urandom;
    end
    dmem_req_i = 1'b0; data_mem_ack_i = 1'b0;
    chk("gnt_cycle", 32'(g), 32'(exp_g));
    chk("err", {31'd0, gerr}, {31'd0, exp_err});
    chk("rdata", grd, exp_rd);
    chk("cyc_cycles", 32'(ncyc), 32'(exp_ncyc));
    chk("cyc_at_1", {31'd0, cyc1}, {31'd0, ~misal});
    chk("bus_fields", {31'd0, bad}, 32'd0);
    tick();
    chk("gnt_pulse", {30'd0, dmem_gnt_o, data_mem_cyc_o}, 32'd0);
  endtask

  initial begin
    logic bad;
    rst = 1'b1;
    dmem_req_i = 0; dmem_wren_i = 0; dmem_ben_i = 0; dmem_usgn_i = 0;
    dmem_addr_i = 0; dmem_wdata_i = 0; data_mem_data_i = 0; data_mem_ack_i = 0;
    repeat (3) tick();
    chk("rst_ctl", {27'd0, dmem_gnt_o, dmem_err_o, data_mem_cyc_o, data_mem_stb_o, data_mem_we_o}, 32'd0);
    chk("rst_wstrb", {28'd0, data_mem_wstrb_o}, 32'd0);
    chk("rst_addr", data_mem_addr_o, 32'd0);
    chk("rst_wdata", data_mem_data_o, 32'd0);
    chk("rst_rdata", dmem_rdata_o, 32'd0);
    rst = 1'b0;
    tick();

    run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80FF1234);
    run(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 2, 32'h80FF1234);
    run(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 1, 32'h5555AAAA);
    run(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h0);
    run(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1, 32'h0);
    run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h12345678);
    run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, T, 32'h12345678);
    run(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 3, 32'h9ABC0000);

    // Back-to-back: req held high through gnt starts the next access.
    dmem_wren_i = 0; dmem_ben_i = 2'b10; dmem_usgn_i = 0; dmem_addr_i = 32'h10; dmem_req_i = 1;
    tick();
    chk("b2b_cyc1", {31'd0, data_mem_cyc_o}, 32'd1);
    data_mem_ack_i = 1; data_mem_data_i = 32'hCAFEF00D;
    tick();
    data_mem_ack_i = 0;
    chk("b2b_gnt1", {31'd0, dmem_gnt_o}, 32'd1);
    chk("b2b_rdata1", dmem_rdata_o, 32'hCAFEF00D);
    tick();
    chk("b2b_gap", {30'd0, data_mem_cyc_o, dmem_gnt_o}, 32'd0);
    tick();
    chk("b2b_cyc2", {31'd0, data_mem_cyc_o}, 32'd1);
    data_mem_ack_i = 1;
    tick();
    data_mem_ack_i = 0; dmem_req_i = 0;
    chk("b2b_gnt2", {31'd0, dmem_gnt_o}, 32'd1);
    tick();

    // Reset during BUS drops cyc immediately and the transaction vanishes.
    dmem_addr_i = 32'h80; dmem_req_i = 1;
    tick();
    dmem_req_i = 0;
    chk("mid_cyc", {31'd0, data_mem_cyc_o}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", {30'd0, data_mem_cyc_o, data_mem_stb_o}, 32'd0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (dmem_gnt_o !== 1'b0 || data_mem_cyc_o !== 1'b0) bad = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, bad}, 32'd0);
    run(1'b0, 2'b00, 1'b1, 32'h81, 32'h0, 2, 32'h0000A500);

    // Spurious ack while idle.
    data_mem_ack_i = 1; bad = 1'b0;
    repeat (3) begin
      tick();
      if (dmem_gnt_o !== 1'b0 || data_mem_cyc_o !== 1'b0) bad = 1'b1;
    end
    data_mem_ack_i = 0;
    chk("spurious_ack", {31'd0, bad}, 32'd0);
    run(1'b1, 2'b00, 1'b0, 32'h301, 32'hFFFFFF5A, 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom_range(0, 6), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
